mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_pkg.sv | 89 ++++++++
 rtl/mc_alu_dec.sv | 40 ++++
 rtl/mc_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: states, ALU ops, immediate
// formats, opcodes and the datapath strobe bundle.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned IMM_W   = 3;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned F3_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [IMM_W-1:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_e;

    // Selects how the ALU decoder interprets funct3/funct7b5
    typedef enum logic [2:0] {
        CLS_ADD    = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_ITYPE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_PASSB  = 3'd4
    } alu_cls_e;

    typedef struct packed {
        logic       mem_write;
        logic       reg_write;
        logic       ir_write;
        logic       adr_src;
        logic       pc_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
    } ctrl_t;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

    // funct3 010/011 never name a branch; the reduced variant supports beq only
    function automatic logic branch_f3_ok(input logic [F3_W-1:0] f3, input logic full);
        if (full) begin
            return (f3 != 3'b010) && (f3 != 3'b011);
        end
        return f3 == 3'b000;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decode from instruction class, funct3 and funct7b5.
module mc_alu_dec
    import mc_pkg::*;
(
    input  alu_cls_e        cls_i,
    input  logic [F3_W-1:0] funct3_i,
    input  logic            funct7b5_i,
    output alu_op_e         alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (cls_i)
            CLS_RTYPE, CLS_ITYPE: begin
                case (funct3_i)
                    3'b000:  alu_ctrl_o = (cls_i == CLS_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl_o = ALU_SLL;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b011:  alu_ctrl_o = ALU_SLTU;
                    3'b100:  alu_ctrl_o = ALU_XOR;
                    3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_AND;
                endcase
            end
            // Branch compare: equality via SUB, ordering via SLT/SLTU
            CLS_BRANCH: begin
                case (funct3_i)
                    3'b000, 3'b001: alu_ctrl_o = ALU_SUB;
                    3'b100, 3'b101: alu_ctrl_o = ALU_SLT;
                    3'b110, 3'b111: alu_ctrl_o = ALU_SLTU;
                    default:        alu_ctrl_o = ALU_ADD;
                endcase
            end
            CLS_PASSB: alu_ctrl_o = ALU_PASSB;
            default:   alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: Moore FSM driving datapath strobes, with
// same-cycle branch resolution and a sticky illegal-instruction trap.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter bit MEM_WAIT    = 1'b0,
    parameter bit FULL_BRANCH = 1'b1
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [F3_W-1:0]    funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               PCWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [IMM_W-1:0]   ImmSrc,
    output logic [ALU_W-1:0]   ALUControl,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_e   state_q, state_d;
    logic     illegal_q, illegal_d;
    ctrl_t    ctrl;
    alu_cls_e alu_cls;
    alu_op_e  alu_op;
    imm_e     imm_sel;
    logic     mem_go;
    logic     taken;

    assign mem_go = !MEM_WAIT || mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // beq/bge/bgeu take on a zero compare result, bne/blt/bltu on non-zero
    always_comb begin
        case (funct3)
            3'b000, 3'b101, 3'b111: taken = Zero;
            default:                taken = !Zero;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        ctrl      = '0;
        alu_cls   = CLS_ADD;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                if (mem_go) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = branch_f3_ok(funct3, FULL_BRANCH) ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                if (mem_go) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                if (mem_go) state_d = S_FETCH;
            end
            S_EXECR: begin
                ctrl.alu_src_a = 2'b10;
                alu_cls = CLS_RTYPE;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                alu_cls = CLS_ITYPE;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.pc_write  = taken;
                alu_cls = CLS_BRANCH;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                ctrl.pc_write  = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ctrl.alu_src_a  = 2'b10;
                ctrl.alu_src_b  = 2'b01;
                ctrl.result_src = 2'b10;
                ctrl.pc_write   = 1'b1;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ctrl.alu_src_b = 2'b01;
                alu_cls = CLS_PASSB;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                state_d = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) illegal_d = 1'b1;
    end

    mc_alu_dec u_alu_dec (
        .cls_i      (alu_cls),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .alu_ctrl_o (alu_op)
    );

    always_comb begin
        case (op)
            OP_STORE:         imm_sel = IMM_S;
            OP_BRANCH:        imm_sel = IMM_B;
            OP_JAL:           imm_sel = IMM_J;
            OP_LUI, OP_AUIPC: imm_sel = IMM_U;
            default:          imm_sel = IMM_I;
        endcase
    end

    // Write strobes are forced low while reset is held, whatever the state
    assign MemWrite   = ctrl.mem_write & ~reset;
    assign RegWrite   = ctrl.reg_write & ~reset;
    assign IRWrite    = ctrl.ir_write  & ~reset;
    assign PCWrite    = ctrl.pc_write  & ~reset;
    assign AdrSrc     = ctrl.adr_src;
    assign ResultSrc  = ctrl.result_src;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ImmSrc     = imm_sel;
    assign ALUControl = alu_op;
    assign illegal    = illegal_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit: instance 0 is the default build,
// instance 1 waits on mem_ready and only supports beq.
module tb_mc_control_unit;
    import mc_pkg::*;

    localparam int NI = 2;

    typedef struct packed {
        logic       mw;
        logic       rw;
        logic       irw;
        logic       adr;
        logic       pcw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
    } strobes_t;

    logic        clk = 1'b0;
    logic        reset      [NI];
    logic [6:0]  op         [NI];
    logic [2:0]  funct3     [NI];
    logic        funct7b5   [NI];
    logic        zero       [NI];
    logic        mem_ready  [NI];
    logic        mem_write  [NI];
    logic        reg_write  [NI];
    logic        ir_write   [NI];
    logic        adr_src    [NI];
    logic        pc_write   [NI];
    logic [1:0]  result_src [NI];
    logic [1:0]  alu_src_a  [NI];
    logic [1:0]  alu_src_b  [NI];
    logic [2:0]  imm_src    [NI];
    logic [3:0]  alu_ctrl   [NI];
    logic        illegal    [NI];
    logic [3:0]  state      [NI];
    logic [31:0] opa        [NI];
    logic [31:0] opb        [NI];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Zero flag of a behavioural ALU for the compare ops branches use
    function automatic logic alu_zero(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0001: return (a - b) == 32'd0;
            4'b0101: return !($signed(a) < $signed(b));
            4'b0110: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mc_control_unit #(.MEM_WAIT(g == 1), .FULL_BRANCH(g == 0)) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .op         (op[g]),
            .funct3     (funct3[g]),
            .funct7b5   (funct7b5[g]),
            .Zero       (zero[g]),
            .mem_ready  (mem_ready[g]),
            .MemWrite   (mem_write[g]),
            .RegWrite   (reg_write[g]),
            .IRWrite    (ir_write[g]),
            .AdrSrc     (adr_src[g]),
            .PCWrite    (pc_write[g]),
            .ResultSrc  (result_src[g]),
            .ALUSrcA    (alu_src_a[g]),
            .ALUSrcB    (alu_src_b[g]),
            .ImmSrc     (imm_src[g]),
            .ALUControl (alu_ctrl[g]),
            .illegal    (illegal[g]),
            .state_o    (state[g])
        );
        assign zero[g] = alu_zero(alu_ctrl[g], opa[g], opb[g]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural branch outcome on the two register operands
    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic state_e exec_state(input int k, input logic [6:0] o, input logic [2:0] f3);
        logic br_ok;
        br_ok = (k == 0) ? (f3 != 3'b010 && f3 != 3'b011) : (f3 == 3'b000);
        case (o)
            7'b0000011, 7'b0100011: return S_MEMADR;
            7'b0110011: return S_EXECR;
            7'b0010011: return S_EXECI;
            7'b1100011: return br_ok ? S_BRANCH : S_TRAP;
            7'b1101111: return S_JAL;
            7'b1100111: return S_JALR;
            7'b0110111: return S_LUI;
            7'b0010111: return S_AUIPC;
            default:    return S_TRAP;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        case (o)
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input state_e s, input logic [2:0] f3, input logic f7);
        if (s == S_EXECR || s == S_EXECI) begin
            case (f3)
                3'b000:  return (s == S_EXECR && f7) ? 4'b0001 : 4'b0000;
                3'b001:  return 4'b0111;
                3'b010:  return 4'b0101;
                3'b011:  return 4'b0110;
                3'b100:  return 4'b0100;
                3'b101:  return f7 ? 4'b1001 : 4'b1000;
                3'b110:  return 4'b0011;
                default: return 4'b0010;
            endcase
        end
        if (s == S_BRANCH) begin
            case (f3[2:1])
                2'b00:   return 4'b0001;
                2'b10:   return 4'b0101;
                default: return 4'b0110;
            endcase
        end
        return (s == S_LUI) ? 4'b1010 : 4'b0000;
    endfunction

    function automatic strobes_t exp_strobes(input state_e s, input logic tk);
        strobes_t e;
        e = '0;
        case (s)
            S_FETCH:    begin e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b10; e.rs = 2'b10; end
            S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
            S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
            S_MEMREAD:  e.adr = 1'b1;
            S_MEMWB:    begin e.rs = 2'b01; e.rw = 1'b1; end
            S_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
            S_EXECR:    e.sa = 2'b10;
            S_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; end
            S_ALUWB:    e.rw = 1'b1;
            S_BRANCH:   begin e.sa = 2'b10; e.pcw = tk; end
            S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            S_JALR:     begin e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1; end
            S_LUI:      e.sb = 2'b01;
            S_AUIPC:    begin e.sa = 2'b01; e.sb = 2'b01; end
            default:    e = '0;
        endcase
        return e;
    endfunction

    task automatic check_cycle(input int k, input state_e s);
        strobes_t got;
        string    tag;
        got = {mem_write[k], reg_write[k], ir_write[k], adr_src[k], pc_write[k],
               result_src[k], alu_src_a[k], alu_src_b[k]};
        tag = $sformatf("i%0d op=%b f3=%b %s", k, op[k], funct3[k], s.name());
        check({tag, " state"}, 32'(state[k]), 32'(s));
        check({tag, " strobes"}, 32'(got), 32'(exp_strobes(s, br_taken(funct3[k], opa[k], opb[k]))));
        check({tag, " ALUControl"}, 32'(alu_ctrl[k]), 32'(exp_alu(s, funct3[k], funct7b5[k])));
        check({tag, " ImmSrc"}, 32'(imm_src[k]), 32'(exp_imm(op[k])));
        check({tag, " illegal"}, 32'(illegal[k]), 32'(s == S_TRAP));
    endtask

    // mode: 0 ready always, 1 random ready, 2 ready low for 3 MEMREAD cycles
    task automatic run_instr(input int k, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b, input int mode,
                             output int cycles, output state_e last);
        state_e path[$];
        state_e s;
        int     idx;
        int     low;
        logic   rdy;
        path.push_back(S_FETCH);
        path.push_back(S_DECODE);
        s = exec_state(k, o, f3);
        path.push_back(s);
        if (s == S_MEMADR) begin
            if (o == 7'b0100011) path.push_back(S_MEMWRITE);
            else begin path.push_back(S_MEMREAD); path.push_back(S_MEMWB); end
        end else if (s != S_BRANCH && s != S_TRAP) begin
            path.push_back(S_ALUWB);
        end
        last = path[path.size() - 1];
        op[k] = o; funct3[k] = f3; funct7b5[k] = f7; opa[k] = a; opb[k] = b;
        idx = 0; cycles = 0; low = 0;
        while (idx < path.size() && cycles < 200) begin
            s = path[idx];
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = !(s == S_MEMREAD && low < 3);
            endcase
            if (s == S_MEMREAD && !rdy) low++;
            mem_ready[k] = rdy;
            @(negedge clk);
            check_cycle(k, s);
            cycles++;
            if (!(k == 1 && !rdy && (s == S_FETCH || s == S_MEMREAD || s == S_MEMWRITE))) idx++;
            @(posedge clk); #1;
        end
        check($sformatf("i%0d cycle budget", k), 32'(cycles < 200), 32'd1);
    endtask

    task automatic reset_dut(input int k);
        reset[k] = 1'b1;
        @(negedge clk);
        check($sformatf("i%0d strobes in reset", k),
              32'({mem_write[k], reg_write[k], ir_write[k], pc_write[k]}), 32'd0);
        @(posedge clk); #1;
        check($sformatf("i%0d state after reset", k), 32'(state[k]), 32'(S_FETCH));
        check($sformatf("i%0d illegal after reset", k), 32'(illegal[k]), 32'd0);
        reset[k] = 1'b0;
    endtask

    task automatic do_instr(input int k, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic [31:0] a, input logic [31:0] b, input int mode,
                            output int cycles);
        state_e last;
        run_instr(k, o, f3, f7, a, b, mode, cycles, last);
        if (last == S_TRAP) begin
            repeat (10) begin
                op[k] = 7'($urandom);
                @(negedge clk);
                check_cycle(k, S_TRAP);
                @(posedge clk); #1;
            end
            reset_dut(k);
        end
    endtask

    task automatic random_instrs(input int k, input int n, input int mode);
        logic [6:0]  o;
        logic [31:0] a;
        int          cyc;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 10))
                0:  o = 7'b0000011;
                1:  o = 7'b0100011;
                2:  o = 7'b0110011;
                3:  o = 7'b0010011;
                4:  o = 7'b1100011;
                5:  o = 7'b1101111;
                6:  o = 7'b1100111;
                7:  o = 7'b0110111;
                8:  o = 7'b0010111;
                9:  o = 7'b1100011;
                default: o = 7'($urandom);
            endcase
            a = $urandom;
            do_instr(k, o, 3'($urandom), 1'($urandom), a,
                     ($urandom_range(0, 3) == 0) ? a : $urandom, mode, cyc);
        end
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < NI; k++) begin
            reset[k] = 1'b1; op[k] = '0; funct3[k] = '0; funct7b5[k] = 1'b0;
            mem_ready[k] = 1'b0; opa[k] = '0; opb[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("i%0d reset state", k), 32'(state[k]), 32'(S_FETCH));
            check($sformatf("i%0d reset illegal", k), 32'(illegal[k]), 32'd0);
            check($sformatf("i%0d reset strobes", k),
                  32'({mem_write[k], reg_write[k], ir_write[k], pc_write[k]}), 32'd0);
        end
        reset[0] = 1'b0;

        do_instr(0, 7'b0110011, 3'b000, 1'b0, 32'd11, 32'd22, 1, cyc);
        check("add cycles", 32'(cyc), 32'd4);
        do_instr(0, 7'b1100011, 3'b001, 1'b0, 32'd5, 32'd9, 1, cyc);
        do_instr(0, 7'b1100011, 3'b001, 1'b0, 32'd7, 32'd7, 1, cyc);
        do_instr(0, 7'b1100011, 3'b101, 1'b0, 32'd3, 32'd3, 1, cyc);
        do_instr(0, 7'b1111111, 3'b000, 1'b0, 32'd0, 32'd0, 1, cyc);
        random_instrs(0, 80, 1);

        reset[0] = 1'b1;
        reset[1] = 1'b0;
        do_instr(1, 7'b0000011, 3'b010, 1'b0, 32'd4, 32'd0, 2, cyc);
        check("lw wait cycles", 32'(cyc), 32'd8);
        do_instr(1, 7'b1100011, 3'b100, 1'b0, 32'd1, 32'd2, 0, cyc);
        random_instrs(1, 60, 1);

        op[1] = 7'b0100011; funct3[1] = 3'b010; mem_ready[1] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready[1] = 1'b0;
        @(posedge clk); #1;
        check("sw stalled state", 32'(state[1]), 32'(S_MEMWRITE));
        check("sw stalled MemWrite", 32'(mem_write[1]), 32'd1);
        reset_dut(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
